regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (we/waddr/wdata) between NREQ writeback
//  requesters: ALU, load unit and multi-cycle multiplier.
//  Each requester has a 1-deep holding slot. A round-robin arbiter drains the slots
//  into a registered write port.
//  Exports a pending-write mask so the issue stage can stall on RAW hazards.
// PARAMETERS
//  NREQ  3   number of writeback requesters (2..8)
//  AW    5   register address width
//  DW    32  register data width
// PORTS
//  clk        in   1        system clock; all state updates on posedge
//  rst_n      in   1        asynchronous active-low reset
//  req_valid  in   NREQ     requester i presents a write
//  req_ready  out  NREQ     requester i write accepted this cycle when valid&ready
//  req_addr   in   NREQ*AW  dest register of requester i (bits i*AW +: AW)
//  req_data   in   NREQ*DW  write data of requester i (bits i*DW +: DW)
//  rf_we      out  1        register-file write enable (registered)
//  rf_waddr   out  AW       register-file write address (registered)
//  rf_wdata   out  DW       register-file write data (registered)
//  pend_mask  out  2**AW    bit r = 1: a write to register r is in flight
// BEHAVIOUR
//  - Reset (async, rst_n=0): all slots empty; rr_ptr=0; rf_we=0; rf_waddr=0; rf_wdata=0;
//    pend_mask=0. Reset mid-operation drops every held write silently.
//  - Slot i: full flag, addr, data. req_ready[i] = ~full[i] | grant[i].
//    This is combinational and gives full throughput per requester.
//  - Accept (valid&ready, addr!=0): slot loads at the edge.
//    A simultaneous grant of the old content and load of the new content is legal.
//  - Accept with addr==0: consumed and discarded; slot stays unchanged, no write is issued.
//  - Arbitration, each cycle: among full slots, grant the first index at or after rr_ptr,
//    wrapping modulo NREQ. At most one grant per cycle.
//  - On grant g: at the edge, rf_we<=1, rf_waddr<=addr[g], rf_wdata<=data[g],
//    full[g] clears unless reloaded, rr_ptr<=(g+1)%NREQ.
//  - No grant: rf_we<=0. rf_waddr and rf_wdata hold their previous values.
//  - Latency: accept at edge N; rf_we high during cycle N+1..N+2 at the earliest.
//    The register file commits at the edge ending the rf_we cycle.
//  - pend_mask[r] = OR over full slots with addr==r, OR (rf_we & rf_waddr==r).
//    It is combinational from state; bit 0 is always 0.
//  - Ordering: no order is guaranteed between different requesters.
//    The issue stage must not dispatch a second write to r while pend_mask[r]=1.
//    Per requester, writes commit in acceptance order.
//  - All requesters continuously full: grants rotate 0,1,..,NREQ-1,0.
//    Worst-case wait for a full slot is NREQ-1 cycles.
// CONFIGURATION
//  WB_BYPASS_EN defined: adds ports
//    byp_raddr1/byp_raddr2 (in, AW), byp_hit1/byp_hit2 (out, 1),
//    byp_data1/byp_data2 (out, DW).
//    byp_hitK = rf_we & (rf_waddr==byp_raddrK) & (byp_raddrK!=0), combinational.
//    byp_dataK = rf_wdata. Decode uses these to forward the write committing this cycle.
//  WB_BYPASS_EN undefined: these ports and their logic are absent; all else is identical.
// TESTING
//  1. Reset then idle: rf_we=0, pend_mask=0, req_ready=all 1 for 10 cycles.
//     Assert rst_n low mid-run with 3 full slots -> outputs return to 0 immediately.
//  2. Single write: req0 addr=5 data=0xDEADBEEF for 1 cycle.
//     -> next cycle pend_mask[5]=1; following cycle rf_we=1, rf_waddr=5,
//     rf_wdata=0xDEADBEEF; then pend_mask[5]=0.
//  3. Contention: req0/1/2 valid in the same cycle, addrs 1/2/3
//     -> rf_we high 3 consecutive cycles with waddr 1,2,3; rr_ptr ends at 0.
//  4. Continuous streams on all three for 30 cycles -> grants strictly rotate.
//     Each requester sees exactly 10 writes and one accept per cycle while its slot drains.
//  5. r0 write: req1 addr=0 data=0x1234 -> req_ready=1, no rf_we, pend_mask unchanged.
//  6. With WB_BYPASS_EN: byp_raddr1=7 while rf_we=1, rf_waddr=7, rf_wdata=0x55
//     -> byp_hit1=1, byp_data1=0x55. byp_raddr2=0 -> byp_hit2=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and the register-file write port.
// The WB_BYPASS_EN macro adds the decode-stage forwarding signals.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic [2**AW-1:0]   pend_mask;
`ifdef WB_BYPASS_EN
    logic [AW-1:0]      byp_raddr1;
    logic [AW-1:0]      byp_raddr2;
    logic               byp_hit1;
    logic               byp_hit2;
    logic [DW-1:0]      byp_data1;
    logic [DW-1:0]      byp_data2;

    modport master (
        output req_valid, req_addr, req_data, byp_raddr1, byp_raddr2,
        input  req_ready, rf_we, rf_waddr, rf_wdata, pend_mask,
               byp_hit1, byp_hit2, byp_data1, byp_data2
    );
    modport slave (
        input  req_valid, req_addr, req_data, byp_raddr1, byp_raddr2,
        output req_ready, rf_we, rf_waddr, rf_wdata, pend_mask,
               byp_hit1, byp_hit2, byp_data1, byp_data2
    );
`else
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_we, rf_waddr, rf_wdata, pend_mask
    );
    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_we, rf_waddr, rf_wdata, pend_mask
    );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one registered register-file write port among NREQ
// one-deep writeback slots. Define WB_BYPASS_EN to add the decode forwarding outputs.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave wb
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] full_q, full_d;
    logic [AW-1:0]   addr_q [NREQ];
    logic [AW-1:0]   addr_d [NREQ];
    logic [DW-1:0]   data_q [NREQ];
    logic [DW-1:0]   data_d [NREQ];
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]   rf_wdata_q, rf_wdata_d;

    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  ready;
    logic             gnt_any;
    logic [PW-1:0]    gnt_idx;
    logic [2**AW-1:0] pend;

    // First full slot at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_any && full_q[PW'(idx)]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
        if (gnt_any) grant[gnt_idx] = 1'b1;
    end

    assign ready        = ~full_q | grant;
    assign wb.req_ready = ready;

    always_comb begin
        full_d     = full_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rf_we_d    = gnt_any;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        rr_ptr_d   = rr_ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) full_d[i] = 1'b0;
            // Writes to r0 are swallowed here so they never occupy a slot.
            if (wb.req_valid[i] && ready[i] && (wb.req_addr[i*AW +: AW] != '0)) begin
                full_d[i] = 1'b1;
                addr_d[i] = wb.req_addr[i*AW +: AW];
                data_d[i] = wb.req_data[i*DW +: DW];
            end
        end
        if (gnt_any) begin
            rf_waddr_d = addr_q[gnt_idx];
            rf_wdata_d = data_q[gnt_idx];
            rr_ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q     <= '0;
            rr_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            full_q     <= full_d;
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            for (int i = 0; i < NREQ; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (full_q[i]) pend[addr_q[i]] = 1'b1;
        end
        if (rf_we_q) pend[rf_waddr_q] = 1'b1;
        pend[0] = 1'b0;
    end

    assign wb.pend_mask = pend;
    assign wb.rf_we     = rf_we_q;
    assign wb.rf_waddr  = rf_waddr_q;
    assign wb.rf_wdata  = rf_wdata_q;

`ifdef WB_BYPASS_EN
    assign wb.byp_hit1  = rf_we_q && (rf_waddr_q == wb.byp_raddr1) && (wb.byp_raddr1 != '0);
    assign wb.byp_hit2  = rf_we_q && (rf_waddr_q == wb.byp_raddr2) && (wb.byp_raddr2 != '0);
    assign wb.byp_data1 = rf_wdata_q;
    assign wb.byp_data2 = rf_wdata_q;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: accepted writes are queued per requester
// and matched against each register-file write as it appears.
module tb_regfile_wb_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) wb();
    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb.slave)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           exp_q [NREQ][$];
    int            seen_src[$];
    logic [AW-1:0] seen_addr[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_writes = 0;
    int            cnt [NREQ];
    int            per_src [NREQ];
    logic [NREQ-1:0] acc;
    bit            done;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb.req_valid[i]         = v;
        wb.req_addr[i*AW +: AW] = a;
        wb.req_data[i*DW +: DW] = d;
    endtask

    task automatic flush_sb();
        for (int i = 0; i < NREQ; i++) exp_q[i].delete();
        seen_src.delete();
        seen_addr.delete();
    endtask

    task automatic apply_reset();
        wb.req_valid = '0;
        wb.req_addr  = '0;
        wb.req_data  = '0;
        rst_n = 1'b0;
        flush_sb();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: retire the write on the port, then record this cycle's accepts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wb.rf_we) begin
                int found;
                found = -1;
                for (int i = 0; i < NREQ; i++) begin
                    if (found < 0 && exp_q[i].size() > 0 && exp_q[i][0] == {wb.rf_waddr, wb.rf_wdata})
                        found = i;
                end
                check_eq("wb_match", 64'(found >= 0), 64'd1);
                if (found >= 0) void'(exp_q[found].pop_front());
                seen_src.push_back(found);
                seen_addr.push_back(wb.rf_waddr);
                n_writes++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (wb.req_valid[i] && wb.req_ready[i] && wb.req_addr[i*AW +: AW] != '0)
                    exp_q[i].push_back({wb.req_addr[i*AW +: AW], wb.req_data[i*DW +: DW]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        bit drained;
        wb.req_valid = '0;
        wb.req_addr  = '0;
        wb.req_data  = '0;
`ifdef WB_BYPASS_EN
        wb.byp_raddr1 = '0;
        wb.byp_raddr2 = '0;
`endif
        apply_reset();

        // Idle after reset
        repeat (10) begin
            @(negedge clk);
            check_eq("idle_we", 64'(wb.rf_we), 64'd0);
            check_eq("idle_pend", 64'(wb.pend_mask), 64'd0);
            check_eq("idle_ready", 64'(wb.req_ready), 64'b111);
        end

        // Single write, latency and pend_mask lifetime
        @(posedge clk); #1 set_req(0, 1'b1, AW'(5), 32'hDEADBEEF);
        @(negedge clk);
        check_eq("single_ready", 64'(wb.req_ready[0]), 64'd1);
        @(posedge clk); #1 set_req(0, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("single_pend_slot", 64'(wb.pend_mask), 64'h20);
        check_eq("single_we_early", 64'(wb.rf_we), 64'd0);
        @(negedge clk);
        check_eq("single_we", 64'(wb.rf_we), 64'd1);
        check_eq("single_waddr", 64'(wb.rf_waddr), 64'd5);
        check_eq("single_wdata", 64'(wb.rf_wdata), 64'hDEADBEEF);
        check_eq("single_pend_port", 64'(wb.pend_mask), 64'h20);
        @(negedge clk);
        check_eq("single_we_off", 64'(wb.rf_we), 64'd0);
        check_eq("single_pend_clr", 64'(wb.pend_mask), 64'd0);

        // r0 write is consumed and discarded
        @(posedge clk); #1 set_req(1, 1'b1, '0, 32'h1234);
        @(negedge clk);
        check_eq("r0_ready", 64'(wb.req_ready[1]), 64'd1);
        check_eq("r0_pend", 64'(wb.pend_mask), 64'd0);
        @(posedge clk); #1 set_req(1, 1'b0, '0, '0);
        wr0 = n_writes;
        repeat (3) begin
            @(negedge clk);
            check_eq("r0_we", 64'(wb.rf_we), 64'd0);
            check_eq("r0_pend_after", 64'(wb.pend_mask), 64'd0);
        end
        check_eq("r0_no_write", 64'(n_writes - wr0), 64'd0);

        // Async reset with three held writes drops them all
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(9 + i), DW'(32'hA00 + i));
        @(posedge clk); #1 wb.req_valid = '0;
        @(posedge clk); #2;
        check_eq("mid_pend_before", 64'(wb.pend_mask), 64'h0E00);
        rst_n = 1'b0;
        flush_sb();
        #1;
        check_eq("mid_rst_we", 64'(wb.rf_we), 64'd0);
        check_eq("mid_rst_pend", 64'(wb.pend_mask), 64'd0);
        check_eq("mid_rst_ready", 64'(wb.req_ready), 64'b111);
        check_eq("mid_rst_waddr", 64'(wb.rf_waddr), 64'd0);
        check_eq("mid_rst_wdata", 64'(wb.rf_wdata), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        wr0 = n_writes;
        repeat (4) @(negedge clk);
        check_eq("mid_rst_dropped", 64'(n_writes - wr0), 64'd0);

        // Contention twice: order 1,2,3 then 4,5,6 shows rr_ptr wrapped to 0
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(3*r + i + 1), DW'(32'h100 + 16*r + i));
            @(posedge clk); #1 wb.req_valid = '0;
            @(negedge clk);
            check_eq("cont_we_pre", 64'(wb.rf_we), 64'd0);
            for (int k = 0; k < NREQ; k++) begin
                @(negedge clk);
                check_eq("cont_we", 64'(wb.rf_we), 64'd1);
                check_eq("cont_waddr", 64'(wb.rf_waddr), 64'(3*r + k + 1));
            end
            @(negedge clk);
            check_eq("cont_we_post", 64'(wb.rf_we), 64'd0);
        end

        // Continuous streams on all requesters
        apply_reset();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0;
            set_req(i, 1'b1, AW'(8 + i), DW'((i << 16) | cnt[i]));
        end
        done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            acc = wb.req_valid & wb.req_ready;
            if (cyc > 0 && wb.req_valid == '1)
                check_eq("stream_one_accept", 64'($countones(acc)), 64'd1);
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 10) set_req(i, 1'b0, '0, '0);
                    else set_req(i, 1'b1, AW'(8 + i), DW'((i << 16) | cnt[i]));
                end
            end
            done = (cnt[0] == 10) && (cnt[1] == 10) && (cnt[2] == 10);
        end
        check_eq("stream_done", 64'(done), 64'd1);
        drained = 1'b0;
        for (int cyc = 0; cyc < 50 && !drained; cyc++) begin
            @(negedge clk);
            drained = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
                      (exp_q[2].size() == 0) && !wb.rf_we;
        end
        check_eq("stream_drained", 64'(drained), 64'd1);
        check_eq("stream_pend", 64'(wb.pend_mask), 64'd0);
        check_eq("stream_total", 64'(seen_src.size()), 64'd30);
        for (int i = 0; i < NREQ; i++) per_src[i] = 0;
        for (int k = 0; k < seen_src.size(); k++) begin
            check_eq("stream_rotate", 64'(seen_src[k]), 64'(k % 3));
            if (seen_src[k] >= 0) per_src[seen_src[k]]++;
        end
        for (int i = 0; i < NREQ; i++) check_eq("stream_per_req", 64'(per_src[i]), 64'd10);

`ifdef WB_BYPASS_EN
        // Forwarding of the write on the port this cycle
        @(posedge clk); #1;
        set_req(2, 1'b1, AW'(7), 32'h55);
        wb.byp_raddr1 = AW'(7);
        wb.byp_raddr2 = '0;
        @(posedge clk); #1 set_req(2, 1'b0, '0, '0);
        @(negedge clk);
        check_eq("byp_hit1_pre", 64'(wb.byp_hit1), 64'd0);
        @(negedge clk);
        check_eq("byp_we", 64'(wb.rf_we), 64'd1);
        check_eq("byp_hit1", 64'(wb.byp_hit1), 64'd1);
        check_eq("byp_data1", 64'(wb.byp_data1), 64'h55);
        check_eq("byp_hit2", 64'(wb.byp_hit2), 64'd0);
        check_eq("byp_data2", 64'(wb.byp_data2), 64'h55);
        @(negedge clk);
        check_eq("byp_hit1_post", 64'(wb.byp_hit1), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
